// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the shared memory and the
// mem_port_arbiter; the arbiter connects through the slave modport.
interface mem_port_arbiter_if #(
  parameter int unsigned MEM_AW = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              err_misaligned;
  logic              err_range;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, err_misaligned, err_range
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, err_misaligned, err_range
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data
// access, with IF aging. Optional grant/conflict counters under MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic               stat_clear,
  output logic [31:0]        stat_if_grants,
  output logic [31:0]        stat_dm_grants,
  output logic [31:0]        stat_conflicts
`endif
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned HI = MEM_AW + 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  owner_t        owner;
  logic          owner_zero;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   if_rdata_q;
  logic [31:0]   dm_rdata_q;
  logic          err_mis_q;
  logic          err_rng_q;

  logic          if_win;
  logic          dm_win;
  logic          grant_any;
  logic [31:0]   sel_addr;
  logic          sel_we;
  logic          sel_mis;
  logic          sel_rng;
  logic          if_ret;
  logic          dm_ret;
  logic [31:0]   ret_data;

  // Data wins by default; an aged fetch overrides it. No grants during reset.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (!reset) begin
      if_win = bus.if_req && (!bus.dm_req || (starve_cnt >= CW'(STARVE_LIMIT)));
      dm_win = bus.dm_req && !if_win;
    end
  end

  always_comb begin
    grant_any = if_win | dm_win;
    sel_addr  = if_win ? bus.if_addr : bus.dm_addr;
    sel_we    = dm_win & bus.dm_we;
    sel_mis   = |sel_addr[1:0];
    sel_rng   = (sel_addr >> HI) != 32'd0;
  end

  // Out-of-range accesses are granted but never reach the memory.
  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.mem_en    = grant_any & ~sel_rng;
  assign bus.mem_we    = sel_we & ~sel_rng;
  assign bus.mem_addr  = sel_addr[HI-1:2];
  assign bus.mem_wdata = bus.dm_wdata;

  // Return path: live memory data in the cycle after a read grant, else the held copy.
  always_comb begin
    if_ret   = (owner == OWN_IF) && !reset;
    dm_ret   = (owner == OWN_DM) && !reset;
    ret_data = owner_zero ? 32'h0 : bus.mem_rdata;
  end

  assign bus.if_rvalid      = if_ret;
  assign bus.dm_rvalid      = dm_ret;
  assign bus.if_rdata       = if_ret ? ret_data : if_rdata_q;
  assign bus.dm_rdata       = dm_ret ? ret_data : dm_rdata_q;
  assign bus.err_misaligned = err_mis_q;
  assign bus.err_range      = err_rng_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_NONE;
      owner_zero <= 1'b0;
      starve_cnt <= '0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
      err_mis_q  <= 1'b0;
      err_rng_q  <= 1'b0;
    end else begin
      if (if_ret) if_rdata_q <= ret_data;
      if (dm_ret) dm_rdata_q <= ret_data;

      if (if_win)                     owner <= OWN_IF;
      else if (dm_win && !bus.dm_we)  owner <= OWN_DM;
      else                            owner <= OWN_NONE;
      owner_zero <= sel_rng;

      if (bus.if_req && !if_win) begin
        if (starve_cnt < CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end

      if (grant_any && sel_mis) err_mis_q <= 1'b1;
      if (grant_any && sel_rng) err_rng_q <= 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Free-running wrap-around counters; reset beats stat_clear.
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_if_grants <= 32'h0;
      stat_dm_grants <= 32'h0;
      stat_conflicts <= 32'h0;
    end else begin
      if (if_win)                    stat_if_grants <= stat_if_grants + 32'd1;
      if (dm_win)                    stat_dm_grants <= stat_dm_grants + 32'd1;
      if (bus.if_req && bus.dm_req)  stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule
